// File: rtl/cpu_divide_seq.sv
// cpu_divide_seq -- multi-cycle restoring divider for the CPU execute stage.
//
// Takes one signed or unsigned division per accepted request. It retires
// BITS_PER_CYCLE quotient bits per ITER cycle and returns the quotient and
// remainder with a one-cycle o_valid pulse. It uses RISC-V semantics:
//   x / 0          -> quotient all ones, remainder x
//   MIN / -1       -> quotient MIN, remainder 0 (signed only)
// The quotient truncates toward zero. A nonzero remainder takes the sign of
// the numerator.
//
// Optional build macro CPU_DIVIDE_FAST_SPECIAL_EN: when defined, divide-by-zero
// and signed overflow skip ITER/FIX and go from PREP straight to DONE.
// Otherwise they take the full path. The results are the same either way.
//
// Parameters
//   WIDTH           operand/result width (>= 4, even)
//   BITS_PER_CYCLE  quotient bits per iteration (1, 2 or 4; divides WIDTH)
// Ports
//   i_clock        clock, rising edge
//   i_reset        synchronous active-high reset
//   i_request      start, taken only while o_ready
//   i_signed       1 = two's complement operands
//   i_numerator    dividend
//   i_denominator  divisor
//   o_ready        high in IDLE and DONE
//   o_valid        one-cycle pulse (DONE); results valid
//   o_result       quotient, held until next o_valid
//   o_remainder    remainder, held until next o_valid

module cpu_divide_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_numerator,
    input  logic [WIDTH-1:0] i_denominator,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef struct packed {
        logic             sgn;
        logic [WIDTH-1:0] num;
        logic [WIDTH-1:0] den;
    } req_t;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    req_t             req_q;
    req_t             req_in;
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic [WIDTH-1:0] quo_q;    // numerator bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] den_mag;

    assign req_in  = {i_signed, i_numerator, i_denominator};
    assign o_ready = (state == S_IDLE) || (state == S_DONE);
    assign o_valid = (state == S_DONE);

    // req_q only changes on accept, so the sign and special-case terms stay
    // stable for the whole operation and need no registers of their own.
    logic             num_neg, den_neg, is_zero, is_ovf;
    logic [WIDTH-1:0] num_abs, den_abs, spec_q, spec_r;

    always_comb begin
        num_neg = req_q.sgn & req_q.num[WIDTH-1];
        den_neg = req_q.sgn & req_q.den[WIDTH-1];
        // Negating MIN gives MIN back, which is the correct unsigned magnitude.
        num_abs = num_neg ? -req_q.num : req_q.num;
        den_abs = den_neg ? -req_q.den : req_q.den;
        is_zero = (req_q.den == '0);
        is_ovf  = req_q.sgn && (req_q.num == MIN_VAL) && (req_q.den == '1);
        spec_q  = is_zero ? '1 : MIN_VAL;
        spec_r  = is_zero ? req_q.num : '0;
    end

    // Unrolled restoring steps. The trial value is one bit wider than the
    // remainder, so the compare against the divisor cannot overflow.
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;

    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        trial  = '0;
        diff   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial  = {rem_nx, quo_nx[WIDTH-1]};
            diff   = {1'b0, trial} - {2'b00, den_mag};
            quo_nx = {quo_nx[WIDTH-2:0], ~diff[WIDTH+1]};
            rem_nx = diff[WIDTH+1] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    logic [WIDTH-1:0] fix_q, fix_r;

    always_comb begin
        fix_q = (num_neg ^ den_neg) ? -quo_q : quo_q;
        fix_r = num_neg ? -rem_q : rem_q;
        if (is_zero || is_ovf) begin
            fix_q = spec_q;
            fix_r = spec_r;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            den_mag     <= '0;
            o_result    <= '0;
            o_remainder <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_request) begin
                        req_q <= req_in;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    rem_q   <= '0;
                    quo_q   <= num_abs;
                    den_mag <= den_abs;
                    cnt     <= CNT_LAST;
`ifdef CPU_DIVIDE_FAST_SPECIAL_EN
                    if (is_zero || is_ovf) begin
                        o_result    <= spec_q;
                        o_remainder <= spec_r;
                        state       <= S_DONE;
                    end else begin
                        state <= S_ITER;
                    end
`else
                    state <= S_ITER;
`endif
                end
                S_ITER: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt == '0) state <= S_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                S_FIX: begin
                    o_result    <= fix_q;
                    o_remainder <= fix_r;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (i_request) begin
                        req_q <= req_in;
                        state <= S_PREP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_divide_seq.sv
// Directed-vector bench for cpu_divide_seq. It uses two instances,
// BITS_PER_CYCLE = 1 and 4, which share the clock, reset and operands.
module tb_cpu_divide_seq;

    logic        clk = 1'b0;
    logic        rst, req1, req4, sgn, sel;
    logic [31:0] num, den;
    logic        rdy1, vld1, rdy4, vld4;
    logic [31:0] res1, rem1, res4, rem4;
    logic        o_rdy, o_vld;
    logic [31:0] o_res, o_rem;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CPU_DIVIDE_FAST_SPECIAL_EN
    localparam int LAT_SPEC1 = 2;
`else
    localparam int LAT_SPEC1 = 35;
`endif

    always #5 clk = ~clk;

    cpu_divide_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_div1 (
        .i_clock(clk), .i_reset(rst), .i_request(req1), .i_signed(sgn),
        .i_numerator(num), .i_denominator(den),
        .o_ready(rdy1), .o_valid(vld1), .o_result(res1), .o_remainder(rem1));

    cpu_divide_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_div4 (
        .i_clock(clk), .i_reset(rst), .i_request(req4), .i_signed(sgn),
        .i_numerator(num), .i_denominator(den),
        .o_ready(rdy4), .o_valid(vld4), .o_result(res4), .o_remainder(rem4));

    assign o_rdy = sel ? rdy4 : rdy1;
    assign o_vld = sel ? vld4 : vld1;
    assign o_res = sel ? res4 : res1;
    assign o_rem = sel ? rem4 : rem1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v);
        req1 = sel ? 1'b0 : v;
        req4 = sel ? v : 1'b0;
    endtask

    // The request is accepted on the first edge, which is edge 0; cycle 1
    // follows it. Returns the cycle in which o_valid is seen, or 200 if it
    // never rises.
    task automatic wait_valid(inout int c);
        while (!o_vld && c < 200) begin
            tick();
            c++;
        end
    endtask

    task automatic run_op(input string tag, input logic s4, input logic sg,
                          input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] eq, input logic [31:0] er, input int lat);
        int c;
        sel = s4; sgn = sg; num = n; den = d;
        set_req(1'b1);
        tick();
        set_req(1'b0);
        c = 1;
        wait_valid(c);
        check({tag, "_lat"}, 64'(c), 64'(lat));
        check({tag, "_q"},   64'(o_res), 64'(eq));
        check({tag, "_r"},   64'(o_rem), 64'(er));
        tick();
        check({tag, "_pulse"}, 64'(o_vld), 64'd0);
    endtask

    // The second request is held from cycle 5 onward. It must be ignored
    // while busy and taken on the edge that leaves DONE.
    task automatic b2b(input string tag, input logic s4, input int lat);
        int c;
        sel = s4; sgn = 1'b0; num = 32'hFFFF_FFFF; den = 32'h0001_0000;
        set_req(1'b1);
        tick();
        set_req(1'b0);
        c = 1;
        while (c < 5) begin
            tick();
            c++;
        end
        num = 32'd1000; den = 32'd10;
        set_req(1'b1);
        check({tag, "_busy_rdy"}, 64'(o_rdy), 64'd0);
        wait_valid(c);
        check({tag, "_lat1"}, 64'(c), 64'(lat));
        check({tag, "_q1"}, 64'(o_res), 64'h0000_FFFF);
        check({tag, "_r1"}, 64'(o_rem), 64'h0000_FFFF);
        check({tag, "_done_rdy"}, 64'(o_rdy), 64'd1);
        tick();
        set_req(1'b0);
        c = 1;
        wait_valid(c);
        check({tag, "_lat2"}, 64'(c), 64'(lat));
        check({tag, "_q2"}, 64'(o_res), 64'd100);
        check({tag, "_r2"}, 64'(o_rem), 64'd0);
        tick();
    endtask

    initial begin
        int c;
        int pulses;
        rst = 1'b1; req1 = 1'b0; req4 = 1'b0; sgn = 1'b0; sel = 1'b0;
        num = '0; den = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy1", 64'(rdy1), 64'd1);
        check("rst_vld1", 64'(vld1), 64'd0);
        check("rst_res1", 64'(res1), 64'd0);
        check("rst_rem1", 64'(rem1), 64'd0);
        check("rst_rdy4", 64'(rdy4), 64'd1);
        check("rst_res4", 64'(res4), 64'd0);

        run_op("u100_7",   1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,        35);
        run_op("s-7_2",    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
        run_op("s7_-2",    1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        35);
        run_op("sdiv0",    1'b0, 1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, LAT_SPEC1);
        run_op("udiv0",    1'b0, 1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, LAT_SPEC1);
        run_op("sovf",     1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        LAT_SPEC1);
        run_op("uminm1",   1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 35);
        run_op("u100_7_4", 1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,        11);
        run_op("s-7_2_4",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 11);

        b2b("b2b1", 1'b0, 35);
        b2b("b2b4", 1'b1, 11);

        // Abort in ITER cycle 10 (cycle 11 after accept). The request is
        // held with the reset to show that reset takes priority.
        sel = 1'b0; sgn = 1'b0; num = 32'd5000; den = 32'd3;
        set_req(1'b1);
        tick();
        set_req(1'b0);
        c = 1;
        while (c < 11) begin
            tick();
            c++;
        end
        rst = 1'b1;
        set_req(1'b1);
        tick();
        rst = 1'b0;
        set_req(1'b0);
        check("abort_rdy", 64'(rdy1), 64'd1);
        check("abort_res", 64'(res1), 64'd0);
        check("abort_rem", 64'(rem1), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (vld1) pulses++;
            tick();
        end
        check("abort_novalid", 64'(pulses), 64'd0);
        run_op("post_abort", 1'b0, 1'b0, 32'd5000, 32'd3, 32'd1666, 32'd2, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
